// File: rtl/port_wr_frontend_if.sv
// Bus bundle for port_wr_frontend.
//   master : the frontend. It receives the input-port word stream, drives the
//            transfer request and burst, and receives the grant.
//   slave  : the surroundings. This is the external input port plus the SRAM
//            selector, which drive the port words and the grant.
// Signals:
//   wr_sop / wr_vld / wr_data / wr_eop
//       input-port packet stream (sop, header, data, eop)
//   xfer_req / xfer_dest / xfer_prio / xfer_len
//       request plus head-packet header fields
//   xfer_grant
//       one-cycle grant from the SRAM selector
//   xfer_data_vld / xfer_data / xfer_end_of_packet
//       burst toward the SRAM input mux
interface port_wr_frontend_if;
    logic        wr_sop;
    logic        wr_vld;
    logic [15:0] wr_data;
    logic        wr_eop;

    logic        xfer_req;
    logic [3:0]  xfer_dest;
    logic [2:0]  xfer_prio;
    logic [8:0]  xfer_len;
    logic        xfer_grant;
    logic        xfer_data_vld;
    logic [15:0] xfer_data;
    logic        xfer_end_of_packet;

    modport master (
        input  wr_sop, wr_vld, wr_data, wr_eop, xfer_grant,
        output xfer_req, xfer_dest, xfer_prio, xfer_len,
               xfer_data_vld, xfer_data, xfer_end_of_packet
    );

    modport slave (
        output wr_sop, wr_vld, wr_data, wr_eop, xfer_grant,
        input  xfer_req, xfer_dest, xfer_prio, xfer_len,
               xfer_data_vld, xfer_data, xfer_end_of_packet
    );
endinterface

// File: rtl/port_wr_frontend.sv
// Per-input-port ingress buffer in front of the per-SRAM write interface.
// Packets from one input port are admitted into a local word FIFO together
// with a header FIFO. Once complete, a packet raises xfer_req. After
// xfer_grant it is streamed, header first, as one contiguous burst.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   bus         : input-port stream and xfer request/burst bus (master side)
//   drop_pulse  : one-cycle pulse per discarded incoming packet
//   free_words  : data FIFO entries not yet reserved
module port_wr_frontend #(
    parameter int DATA_DEPTH = 512,
    parameter int HDR_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    port_wr_frontend_if.master          bus,
    output logic                        drop_pulse,
    output logic [$clog2(DATA_DEPTH):0] free_words
);
    localparam int DATA_W = 16;
    localparam int AW     = $clog2(DATA_DEPTH);
    localparam int HW     = $clog2(HDR_DEPTH);
    localparam int FW     = AW + 1;
    localparam logic [AW-1:0] AONE = AW'(1);
    localparam logic [HW:0]   HONE = (HW+1)'(1);
    localparam logic [FW-1:0] FONE = FW'(1);
    localparam logic [8:0]    LONE = 9'd1;

    typedef enum logic [1:0] {R_IDLE, R_HDR, R_DATA, R_DROP} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_REQ, T_XFER, T_EOP} tx_state_t;

    logic [DATA_W-1:0] data_mem [DATA_DEPTH];
    logic [DATA_W-1:0] hdr_mem  [HDR_DEPTH];

    rx_state_t         rx_state;
    tx_state_t         tx_state;
    logic [AW-1:0]     wptr, pkt_start, rptr;
    logic [HW:0]       hwptr, hrptr, pkt_cnt;
    logic [8:0]        rx_left, tx_left;
    logic [FW-1:0]     rsv_words;
    logic              req_r, eop_r;
    logic [3:0]        dest_r;
    logic [2:0]        prio_r;
    logic [8:0]        len_r;
    logic              vld_p1;
    logic [DATA_W-1:0] rd_data_p1;

    logic [8:0]        hdr_len;
    logic [FW-1:0]     need_words;
    logic              hdr_full, admit, reject, abort_any, abort_data;
    logic              commit, rx_write, rd_en, pop;

    // Decode of the current input word; all of it is qualified by rx_state.
    assign hdr_len    = bus.wr_data[15:7];
    assign need_words = FW'(hdr_len) + FONE;
    // Header pointers carry one extra bit so that full and empty can be told apart.
    assign hdr_full   = (hwptr[HW] != hrptr[HW]) && (hwptr[HW-1:0] == hrptr[HW-1:0]);
    assign admit      = (rx_state == R_HDR) && bus.wr_vld && (free_words >= need_words) && !hdr_full;
    assign reject     = (rx_state == R_HDR) && bus.wr_vld && !admit;
    assign abort_data = (rx_state == R_DATA) && bus.wr_sop;
    assign abort_any  = abort_data || ((rx_state == R_DROP) && bus.wr_sop);
    assign commit     = (rx_state == R_DATA) && !bus.wr_sop && bus.wr_eop;
    // Words beyond the announced length are not written, so a packet can never
    // overrun the space reserved for it.
    assign rx_write   = (rx_state == R_DATA) && !bus.wr_sop && !bus.wr_eop && bus.wr_vld && (rx_left != '0);
    // The header word is read on the grant edge, so it is on the bus right at g+1.
    assign rd_en      = ((tx_state == T_REQ) && bus.xfer_grant) || ((tx_state == T_XFER) && (tx_left != '0));
    assign pop        = (tx_state == T_EOP);

    assign bus.xfer_req           = req_r;
    assign bus.xfer_dest          = dest_r;
    assign bus.xfer_prio          = prio_r;
    assign bus.xfer_len           = len_r;
    assign bus.xfer_data_vld      = vld_p1;
    assign bus.xfer_data          = rd_data_p1;
    assign bus.xfer_end_of_packet = eop_r;

    // Storage writes: the header goes to both FIFOs when the packet is admitted.
    always_ff @(posedge clk) begin
        if (admit || rx_write) data_mem[wptr] <= bus.wr_data;
        if (admit)             hdr_mem[hwptr[HW-1:0]] <= bus.wr_data;
    end

    // ---- stage p1: block-RAM read register feeding the burst ----
    always_ff @(posedge clk) begin
        if (!rst_n)     rd_data_p1 <= '0;
        else if (rd_en) rd_data_p1 <= data_mem[rptr];
    end

    // Receive FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state   <= R_IDLE;
            wptr       <= '0;
            pkt_start  <= '0;
            hwptr      <= '0;
            rx_left    <= '0;
            rsv_words  <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= reject || abort_any;
            unique case (rx_state)
                R_IDLE: if (bus.wr_sop) rx_state <= R_HDR;
                R_HDR: begin
                    if (admit) begin
                        pkt_start <= wptr;
                        wptr      <= wptr + AONE;
                        hwptr     <= hwptr + HONE;
                        rx_left   <= hdr_len;
                        rsv_words <= need_words;
                        rx_state  <= R_DATA;
                    end else if (reject) begin
                        rx_state  <= R_DROP;
                    end
                end
                R_DATA: begin
                    if (bus.wr_sop) begin
                        // Missing eop: forget the partial packet and restart on this sop.
                        wptr     <= pkt_start;
                        hwptr    <= hwptr - HONE;
                        rx_state <= R_HDR;
                    end else if (bus.wr_eop) begin
                        rx_state <= R_IDLE;
                    end else if (rx_write) begin
                        wptr    <= wptr + AONE;
                        rx_left <= rx_left - LONE;
                    end
                end
                R_DROP: begin
                    if (bus.wr_sop)      rx_state <= R_HDR;
                    else if (bus.wr_eop) rx_state <= R_IDLE;
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // Transmit FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= T_IDLE;
            rptr     <= '0;
            hrptr    <= '0;
            tx_left  <= '0;
            req_r    <= 1'b0;
            vld_p1   <= 1'b0;
            eop_r    <= 1'b0;
            dest_r   <= '0;
            prio_r   <= '0;
            len_r    <= '0;
        end else begin
            if (rd_en) rptr <= rptr + AONE;
            unique case (tx_state)
                T_IDLE: begin
                    if (pkt_cnt != '0) begin
                        {len_r, prio_r, dest_r} <= hdr_mem[hrptr[HW-1:0]];
                        req_r    <= 1'b1;
                        tx_state <= T_REQ;
                    end
                end
                T_REQ: begin
                    if (bus.xfer_grant) begin
                        req_r    <= 1'b0;
                        vld_p1   <= 1'b1;
                        tx_left  <= len_r;
                        tx_state <= T_XFER;
                    end
                end
                T_XFER: begin
                    // tx_left counts words still to be fetched after the one on the bus.
                    if (tx_left != '0) begin
                        tx_left <= tx_left - LONE;
                    end else begin
                        vld_p1   <= 1'b0;
                        eop_r    <= 1'b1;
                        tx_state <= T_EOP;
                    end
                end
                T_EOP: begin
                    eop_r    <= 1'b0;
                    hrptr    <= hrptr + HONE;
                    tx_state <= T_IDLE;
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    // Shared counters: reservation at admission, release per word read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            free_words <= FW'(DATA_DEPTH);
            pkt_cnt    <= '0;
        end else begin
            free_words <= free_words
                        - (admit      ? need_words : '0)
                        + (abort_data ? rsv_words  : '0)
                        + (rd_en      ? FONE       : '0);
            if (commit && !pop)      pkt_cnt <= pkt_cnt + HONE;
            else if (pop && !commit) pkt_cnt <= pkt_cnt - HONE;
        end
    end
endmodule

// File: doc/port_wr_frontend.md
# port_wr_frontend

Per-input-port ingress buffer sitting directly upstream of the per-SRAM write interface. Captures packets from one external input port, checks them into a local word FIFO, and raises a transfer request carrying destination, priority and length. Once granted, it streams the packet (header word first) as a contiguous burst on the xfer bus. That bus is the one each SRAM interface consumes through its 16:1 input mux.

## Interface
Parameters:
- DATA_DEPTH, 512: data FIFO depth in 16-bit words; power of two, ≥ 257.
- HDR_DEPTH, 4: header FIFO depth in packets; power of two.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- wr_sop  in  1  start-of-packet pulse, one cycle before the header word
- wr_vld  in  1  input word valid
- wr_data  in  16  input word; the first word after sop is the header: [15:7] data length L (1..256), [6:4] priority, [3:0] destination port
- wr_eop  in  1  end-of-packet pulse, one cycle after the last data word
- xfer_req  out  1  complete packet waiting, level
- xfer_dest  out  4  header[3:0] of the head packet
- xfer_prio  out  3  header[6:4] of the head packet
- xfer_len  out  9  header[15:7] of the head packet
- xfer_grant  in  1  one-cycle grant from the SRAM selector
- xfer_data_vld  out  1  burst word valid
- xfer_data  out  16  burst word
- xfer_end_of_packet  out  1  pulse, one cycle after the last burst word
- drop_pulse  out  1  one-cycle pulse when an incoming packet is discarded
- free_words  out  10  unused data FIFO entries (width clog2(DATA_DEPTH)+1)

## Operation
- Receive FSM states:
  - R_IDLE: on wr_sop, go to R_HDR.
  - R_HDR: on the first wr_vld, check admission. The packet is admitted when free_words ≥ L+1 and the header FIFO is not full.
    - Admitted: write the header into both FIFOs, go to R_DATA.
    - Not admitted: pulse drop_pulse, go to R_DROP.
  - R_DATA: each wr_vld writes one word. On wr_eop, go to R_IDLE. The header-FIFO entry becomes visible to the transmit side only at this point, so pkt_cnt increments here.
  - R_DROP: ignore words until wr_eop, then go to R_IDLE.
- Admission reserves the space. free_words is decremented by L+1 in the admission cycle, not per word.
- A new wr_sop in R_DATA/R_DROP (missing eop) aborts the current packet:
  - Discard its written words (roll the write pointer back to the packet start).
  - Restore its reserved space.
  - Pulse drop_pulse, then go to R_HDR.
- Transmit FSM states:
  - T_IDLE: when pkt_cnt > 0, go to T_REQ.
  - T_REQ: xfer_req=1, with dest/prio/len from the header-FIFO head. On xfer_grant, go to T_XFER.
  - T_XFER: emit L+1 words, one per cycle, xfer_data_vld high throughout. The header comes first, then the data words in order.
  - T_EOP: pulse xfer_end_of_packet. Pop the header FIFO, decrement pkt_cnt, go to T_IDLE.
- free_words increments by 1 per burst word read.
- Receive and transmit run concurrently. A packet may be received while an earlier one is bursting.
- Pointers wrap modulo the depth; only the low log2 bits address the FIFO.
- Same-cycle admission decrement and read increment: free_words changes by the net value.
- pkt_cnt increment and decrement in the same cycle: net unchanged.

## Timing
- Reset values:
  - FSMs: R_IDLE, T_IDLE.
  - FIFOs: empty.
  - free_words = DATA_DEPTH.
  - All other outputs 0.
- Data FIFO is block RAM with 1-cycle read. The head word is prefetched in T_REQ so the burst has no bubble.
- Burst timing: grant at cycle g → xfer_data_vld high for cycles g+1 … g+L+1 → xfer_end_of_packet at g+L+2 → xfer_req low from g+1.
- xfer_req reasserts no earlier than g+L+3.
- xfer_grant outside T_REQ is ignored.
- Minimum latency: eop at cycle e → xfer_req at e+2.
- Reset mid-operation discards all buffered and in-flight packets. No xfer_end_of_packet is emitted.

## Test plan
- Single packet, L=3, dest 5, prio 2, header 0x01A5 + data 0x1111..0x3333; grant 4 cycles after req → xfer_dest=5, xfer_prio=2, xfer_len=3; burst 0x01A5,0x1111,0x2222,0x3333 on g+1..g+4; eop at g+5; free_words back to 512.
- Two back-to-back packets (L=256, L=1) with the second received during the first burst → both bursts in order, header FIFO order preserved, pkt_cnt returns to 0.
- Overflow: hold grant low and fill with one L=256 packet (free 255), then send an L=255 packet → drop_pulse once, its words ignored, free_words stays 255. Next L=254 is admitted.
- Header FIFO full: 4 ungranted L=1 packets, then a 5th → drop_pulse; after one grant a 6th is admitted.
- Pointer wrap: stream 10 packets of L=200 with immediate grants → every burst word matches its input, no corruption across the 512 boundary.
- Reset asserted mid-burst at word 3 → next cycle all outputs 0 and free_words=512. A fresh packet afterwards transfers correctly.
